// File: rtl/pipelined_csa_adder.sv
// pipelined_csa_adder: NBLK-stage carry-select adder/subtractor with valid/ready flow control (optional ovf via CSA_OVF_EN)
//   clk, rst_n (async, active-low) | in_valid/in_ready, a, b, cin, sub in | out_valid/out_ready, sum, cout[, ovf] out
module pipelined_csa_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CSA_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int NBLK = WIDTH / BLOCK;
  logic en;
  logic [WIDTH-1:0] ai [NBLK], bi [NBLK], si [NBLK], sn [NBLK], ar [NBLK], br [NBLK], sr [NBLK];
  logic ci [NBLK], vi [NBLK], vr [NBLK], cr [NBLK];
  logic [BLOCK:0] r0 [NBLK], r1 [NBLK], rs [NBLK];
  assign en = !out_valid | out_ready;
  assign in_ready = en;
  assign out_valid = vr[NBLK-1];
  assign sum = sr[NBLK-1];
  assign cout = cr[NBLK-1];
  // operands travel shifted down so each stage always finds its block in the low BLOCK bits
  always_comb begin
    ai[0] = a;
    bi[0] = sub ? ~b : b;
    ci[0] = sub | cin;
    vi[0] = in_valid;
    si[0] = '0;
    for (int k = 1; k < NBLK; k++) begin
      ai[k] = ar[k-1];
      bi[k] = br[k-1];
      ci[k] = cr[k-1];
      vi[k] = vr[k-1];
      si[k] = sr[k-1];
    end
    for (int k = 0; k < NBLK; k++) begin
      r0[k] = {1'b0, ai[k][BLOCK-1:0]} + {1'b0, bi[k][BLOCK-1:0]};
      r1[k] = {1'b0, ai[k][BLOCK-1:0]} + {1'b0, bi[k][BLOCK-1:0]} + (BLOCK+1)'(1);
      rs[k] = ci[k] ? r1[k] : r0[k];
      sn[k] = si[k] | (WIDTH'(rs[k][BLOCK-1:0]) << (k * BLOCK));
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < NBLK; k++) begin
        vr[k] <= 1'b0;
        cr[k] <= 1'b0;
        sr[k] <= '0;
        ar[k] <= '0;
        br[k] <= '0;
      end
    end else if (en) begin
      for (int k = 0; k < NBLK; k++) begin
        vr[k] <= vi[k];
        cr[k] <= rs[k][BLOCK];
        sr[k] <= sn[k];
        ar[k] <= ai[k] >> BLOCK;
        br[k] <= bi[k] >> BLOCK;
      end
    end
`ifdef CSA_OVF_EN
  logic ovf_r;
  // carry into the MSB is recovered from the MSB's own operand and sum bits
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf_r <= 1'b0;
    else if (en) ovf_r <= ai[NBLK-1][BLOCK-1] ^ bi[NBLK-1][BLOCK-1] ^ rs[NBLK-1][BLOCK-1] ^ rs[NBLK-1][BLOCK];
  assign ovf = ovf_r & out_valid;
`endif
endmodule

// File: tb/tb_pipelined_csa_adder.sv
// tb_pipelined_csa_adder: directed and streamed checks of pipelined_csa_adder (16/4 and 8/8)
module tb_pipelined_csa_adder;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic in_valid = 1'b0, cin = 1'b0, sub = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, cout;
  logic [15:0] a = '0, b = '0, sum;
  logic v8 = 1'b0, c8 = 1'b0, sub8 = 1'b0, ordy8 = 1'b1;
  logic rdy8, ov8, cout8;
  logic [7:0] a8 = '0, b8 = '0, sum8;
`ifdef CSA_OVF_EN
  logic ovf, ovf8;
`endif
  pipelined_csa_adder #(.WIDTH(16), .BLOCK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef CSA_OVF_EN
    , .ovf(ovf)
`endif
  );
  pipelined_csa_adder #(.WIDTH(8), .BLOCK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .a(a8), .b(b8), .cin(c8), .sub(sub8),
    .out_valid(ov8), .out_ready(ordy8), .sum(sum8), .cout(cout8)
`ifdef CSA_OVF_EN
    , .ovf(ovf8)
`endif
  );
  int n_cmp = 0, n_bad = 0, got = 0, pushed = 0;
  logic [17:0] q[$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s);
    logic [16:0] r;
    logic o;
    r = s ? {1'b0, x} + {1'b0, ~y} + 17'd1 : {1'b0, x} + {1'b0, y} + 17'(c);
    o = s ? (x[15] != y[15]) && (r[15] != x[15]) : (x[15] == y[15]) && (r[15] != x[15]);
    return {o, r};
  endfunction
  task automatic tick();
    logic [17:0] e;
    #1;
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious", 1, 0);
      else begin
        e = q.pop_front();
        chk("sb_sum", sum, e[15:0]);
        chk("sb_cout", cout, e[16]);
`ifdef CSA_OVF_EN
        chk("sb_ovf", ovf, e[17]);
`endif
        got++;
      end
    end
    if (in_valid && in_ready) begin
      q.push_back(model(a, b, cin, sub));
      pushed++;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic one(input string tag, input logic [15:0] ta, input logic [15:0] tb, input logic tc, input logic ts,
                     input logic [15:0] es, input logic ec, input logic eo);
    int n;
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 12) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, 4);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
`ifdef CSA_OVF_EN
    chk({tag, "_ovf"}, ovf, eo);
`else
    if (eo === 1'bx) chk({tag, "_eo"}, eo, 0);
`endif
    tick();
  endtask
  initial begin
    int g0, p0, n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov", out_valid, 0);
    chk("rst_rdy", in_ready, 1);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ov8", ov8, 0);
    chk("rst_rdy8", rdy8, 1);
`ifdef CSA_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    rst_n = 1'b1;
    a8 = 8'h80; b8 = 8'h80; c8 = 1'b1; v8 = 1'b1;
    @(posedge clk);
    #1;
    v8 = 1'b0;
    chk("n1_ov", ov8, 1);
    chk("n1_sum", sum8, 8'h01);
    chk("n1_cout", cout8, 1);
`ifdef CSA_OVF_EN
    chk("n1_ovf", ovf8, 1);
`endif
    @(posedge clk);
    #1;
    chk("n1_drop", ov8, 0);
    one("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    one("povf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    one("sub35", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    one("sub53", 16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
    one("addc", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    one("novf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    g0 = got;
    for (int i = 0; i < 28; i++) begin
      in_valid = i < 20;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      tick();
      chk("stream_v", out_valid, (i >= 3 && i < 23));
    end
    chk("stream_n", got - g0, 20);
    g0 = got;
    p0 = pushed;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      tick();
    end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      #1;
      chk("stall_rdy", in_ready, 0);
      chk("stall_v", out_valid, 1);
      chk("stall_sum", sum, (q.size() > 0) ? q[0][15:0] : 16'hDEAD);
      tick();
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 12) begin
      tick();
      n++;
    end
    chk("stall_drain", q.size(), 0);
    chk("stall_cnt", got - g0, pushed - p0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      tick();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_ov", out_valid, 0);
    chk("mrst_rdy", in_ready, 1);
    chk("mrst_sum", sum, 0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mrst_stale", out_valid, 0);
    end
    one("post", 16'h00F0, 16'h0F10, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
